peasant_mult_ctrl: RTL and testbench

//   Sequential unsigned multiplier controller using the Russian-peasant algorithm.

---
 rtl/peasant_mult_pkg.sv | 12 +
 rtl/peasant_step.sv | 20 ++
 rtl/peasant_mult_ctrl.sv | 89 ++++++++
 tb/tb_peasant_mult_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/peasant_mult_pkg.sv
// Shared types and constants for the Russian-peasant multiplier.
package peasant_mult_pkg;

    localparam int PM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pm_state_t;

endpackage

// File: rtl/peasant_step.sv
// One combinational halve/double/conditional-add iteration of the peasant algorithm.
module peasant_step
    import peasant_mult_pkg::*;
#(
    parameter int WIDTH = PM_WIDTH
) (
    input  logic [2*WIDTH-1:0] a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] a_next,
    output logic [WIDTH-1:0]   b_next,
    output logic [2*WIDTH-1:0] acc_next
);

    // The top bit of a can only be shifted out after more than WIDTH steps.
    assign a_next   = a << 1;
    assign b_next   = b >> 1;
    assign acc_next = b[0] ? (acc + a) : acc;

endmodule

// File: rtl/peasant_mult_ctrl.sv
// Sequential unsigned multiplier: handshake control and operand registers around peasant_step.
module peasant_mult_ctrl
    import peasant_mult_pkg::*;
#(
    parameter int WIDTH = PM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy
);

    pm_state_t              state_reg;
    pm_state_t              state_next;
    logic [2*WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]       b_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [2*WIDTH-1:0]     a_step;
    logic [WIDTH-1:0]       b_step;
    logic [2*WIDTH-1:0]     acc_step;

    peasant_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a_reg),
        .b        (b_reg),
        .acc      (acc_reg),
        .a_next   (a_step),
        .b_next   (b_step),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE:    if (in_valid)     state_next = RUN;
                RUN:     if (b_reg == '0)  state_next = DONE;
                DONE:    if (out_ready)    state_next = IDLE;
                default:                   state_next = IDLE;
            endcase
        end
    end

    // Datapath registers only move on a load or a live step; a flush leaves them as-is
    // because the next accept reloads all three.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
        end else if (!flush) begin
            if (state_reg == IDLE && in_valid) begin
                a_reg   <= {{WIDTH{1'b0}}, in_a};
                b_reg   <= in_b;
                acc_reg <= '0;
            end else if (state_reg == RUN && b_reg != '0) begin
                a_reg   <= a_step;
                b_reg   <= b_step;
                acc_reg <= acc_step;
            end
        end
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        busy      = (state_reg == RUN) || (state_reg == DONE);
        out_valid = (state_reg == DONE);
        out_prod  = (state_reg == DONE) ? acc_reg : '0;
    end

endmodule

// File: tb/tb_peasant_mult_ctrl.sv
// Self-checking bench for peasant_mult_ctrl: directed cases plus randomized operands.
module tb_peasant_mult_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_prod;
    logic           busy;

    int checks = 0;
    int errors = 0;

    peasant_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int bitlen(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: an accepted pair yields a*b after bitlen(b)+1 cycles,
    // then is held until consumed. phase 0 = free, 1 = computing, 2 = result on offer.
    int             m_phase = 0;
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_prod  <= '0;
        end else if (flush) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_prod  <= (2*W)'(in_a) * (2*W)'(in_b);
                    m_left  <= bitlen(in_b) + 1;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", in_ready, m_phase == 0);
        chk("cyc_busy", busy, m_phase != 0);
        chk("cyc_out_valid", out_valid, m_phase == 2);
        if (m_phase == 2) chk("cyc_out_prod", out_prod, m_prod);
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_prod, input int exp_lat, input int hold);
        int lat;
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("in_ready_before_op", in_ready, 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("product", out_prod, exp_prod);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            in_a = $urandom;
            in_b = $urandom;
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_prod", out_prod, exp_prod);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("released_valid", out_valid, 0);
        chk("released_in_ready", in_ready, 1);
        $display("op a=%0d b=%0d prod=%0d latency=%0d hold=%0d", a, b, out_prod, lat, hold);
    endtask

    task automatic flush_op(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (k) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        $display("flush a=%0d b=%0d after %0d cycles", a, b, k);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) tick();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_prod", out_prod, 0);
        rst_n = 1'b1;
        tick();

        run_op(32'd13, 32'd11, 64'd143, 5, 0);
        run_op(32'd0, 32'hFFFF_FFFF, 64'd0, 33, 0);
        run_op(32'hFFFF_FFFF, 32'd0, 64'd0, 1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0);
        run_op(32'd13, 32'd11, 64'd143, 5, 10);

        // Flush landing in the third RUN cycle.
        flush_op(32'd7, 32'd255, 2);
        repeat (3) tick();
        chk("post_flush_valid", out_valid, 0);
        run_op(32'd6, 32'd7, 64'd42, 4, 0);

        // Asynchronous reset in the middle of a computation.
        in_a = 32'd7;
        in_b = 32'd255;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_prod", out_prod, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'd100, 32'd200, 64'd20000, 9, 0);

        for (int n = 0; n < 40; n++) begin
            ra = (n % 7 == 3) ? '0 : W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, W);
            if (n % 5 == 4) begin
                flush_op(ra, rb, $urandom_range(0, bitlen(rb) + 2));
            end else begin
                run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), bitlen(rb) + 1, $urandom_range(0, 3));
            end
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
